// File: rtl/mul_xbit_shift.sv
// ---------------------------------------------------------------------------
// mul_xbit_shift
//   Sequential unsigned shift-and-add multiplier. Each clock in CALC adds the
//   multiplicand (gated by the current multiplier LSB) into the high half of
//   the running product, then shifts the whole product right by one. After
//   DATA_WIDTH steps the 2*DATA_WIDTH-bit product is presented in DONE.
//
// Ports
//   i_clk    : clock, rising edge
//   i_rst_n  : asynchronous active-low reset
//   i_valid  : operands on i_num_a / i_num_b are valid
//   o_ready  : block accepts operands (IDLE only)
//   i_num_a  : multiplicand, unsigned, DATA_WIDTH bits
//   i_num_b  : multiplier, unsigned, DATA_WIDTH bits
//   o_valid  : o_res holds a completed product (DONE only)
//   i_ready  : downstream accepts o_res
//   o_res    : product, 2*DATA_WIDTH bits
//
// Also contains adder_xbit_ahead, the carry-lookahead adder used for the
// partial-product accumulation.
// ---------------------------------------------------------------------------

// adder_xbit_ahead
//   DATA_WIDTH-bit carry-lookahead adder. Each carry is computed directly
//   from generate/propagate terms and the carry-in, without rippling.
// Ports
//   i_num_a, i_num_b : addends
//   i_cry            : carry in
//   o_res            : sum
//   o_cry            : carry out
module adder_xbit_ahead #(
  parameter int DATA_WIDTH = 4
) (
  input  logic [DATA_WIDTH-1:0] i_num_a,
  input  logic [DATA_WIDTH-1:0] i_num_b,
  input  logic                  i_cry,
  output logic [DATA_WIDTH-1:0] o_res,
  output logic                  o_cry
);

  logic [DATA_WIDTH-1:0] gen;
  logic [DATA_WIDTH-1:0] prop;
  logic [DATA_WIDTH:0]   carry;

  assign gen      = i_num_a & i_num_b;
  assign prop     = i_num_a ^ i_num_b;
  assign carry[0] = i_cry;

  genvar gi;
  generate
    for (gi = 0; gi < DATA_WIDTH; gi++) begin : g_cla
      logic cla_bit;

      // carry into bit gi+1 = OR over j of (g[j] & p[j+1..gi]) | (p[0..gi] & cin)
      always_comb begin
        logic prop_run;
        cla_bit  = i_cry;
        for (int k = 0; k <= gi; k++) begin
          cla_bit = cla_bit & prop[k];
        end
        for (int j = 0; j <= gi; j++) begin
          prop_run = 1'b1;
          for (int k = j + 1; k <= gi; k++) begin
            prop_run = prop_run & prop[k];
          end
          cla_bit = cla_bit | (gen[j] & prop_run);
        end
      end

      assign carry[gi+1] = cla_bit;
      assign o_res[gi]   = prop[gi] ^ carry[gi];
    end
  endgenerate

  assign o_cry = carry[DATA_WIDTH];

endmodule

module mul_xbit_shift #(
  parameter int DATA_WIDTH = 4
) (
  input  logic                    i_clk,
  input  logic                    i_rst_n,
  input  logic                    i_valid,
  output logic                    o_ready,
  input  logic [DATA_WIDTH-1:0]   i_num_a,
  input  logic [DATA_WIDTH-1:0]   i_num_b,
  output logic                    o_valid,
  input  logic                    i_ready,
  output logic [2*DATA_WIDTH-1:0] o_res
);

  localparam int CNT_W = $clog2(DATA_WIDTH + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state_reg;
  state_t state_next;

  logic [DATA_WIDTH-1:0]   r_mcand;
  logic [2*DATA_WIDTH:0]   r_prod;   // {carry, high half, low half}
  logic [CNT_W-1:0]        r_cnt;

  logic [DATA_WIDTH-1:0]   add_b;
  logic [DATA_WIDTH-1:0]   sum;
  logic                    carry;
  logic                    last_step;

  // The low half starts as the multiplier; its LSB selects each partial product.
  assign add_b = r_prod[0] ? r_mcand : '0;

  adder_xbit_ahead #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_adder (
    .i_num_a(r_prod[2*DATA_WIDTH-1:DATA_WIDTH]),
    .i_num_b(add_b),
    .i_cry  (1'b0),
    .o_res  (sum),
    .o_cry  (carry)
  );

  assign last_step = (r_cnt == CNT_W'(DATA_WIDTH - 1));

  // State register
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next-state decode
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (i_valid)   state_next = CALC;
      CALC:    if (last_step) state_next = DONE;
      DONE:    if (i_ready)   state_next = IDLE;
      default:                state_next = IDLE;
    endcase
  end

  // Datapath registers
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_mcand <= '0;
      r_prod  <= '0;
      r_cnt   <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (i_valid) begin
            r_mcand <= i_num_a;
            r_prod  <= {1'b0, {DATA_WIDTH{1'b0}}, i_num_b};
            r_cnt   <= '0;
          end
        end
        CALC: begin
          // Carry is kept as the top bit, then everything shifts right once;
          // the consumed multiplier LSB falls off the bottom.
          r_prod <= {1'b0, carry, sum, r_prod[DATA_WIDTH-1:1]};
          r_cnt  <= r_cnt + 1'b1;
        end
        default: ; // DONE holds everything until the output handshake
      endcase
    end
  end

  // Outputs decoded from registered state only
  assign o_ready = (state_reg == IDLE);
  assign o_valid = (state_reg == DONE);
  assign o_res   = r_prod[2*DATA_WIDTH-1:0];

endmodule
